// File: rtl/nway_cache.sv
// N-way set-associative, write-back / write-allocate line cache with tree-PLRU replacement.
module nway_cache #(
    parameter int unsigned S_OFFSET = 5,
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned NUM_WAYS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [31:0]                 mem_address,
    input  logic [8*(2**S_OFFSET)-1:0]  mem_wdata256,
    input  logic [(2**S_OFFSET)-1:0]    mem_byte_enable256,
    output logic [8*(2**S_OFFSET)-1:0]  mem_rdata256,
    output logic                        mem_resp,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [31:0]                 pmem_address,
    output logic [8*(2**S_OFFSET)-1:0]  pmem_wdata256,
    input  logic [8*(2**S_OFFSET)-1:0]  pmem_rdata256,
    input  logic                        pmem_resp
);

    localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int unsigned S_MASK   = 2**S_OFFSET;
    localparam int unsigned S_LINE   = 8 * S_MASK;
    localparam int unsigned WIDTH    = $clog2(NUM_WAYS);
    localparam int unsigned NUM_SETS = 2**S_INDEX;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    // Storage: line and tag arrays keep their contents across reset; status bits do not.
    logic [S_LINE-1:0]                   line_q [NUM_SETS][NUM_WAYS];
    logic [S_TAG-1:0]                    tag_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   valid_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   dirty_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:1]   plru_q;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   victim_q, victim_n;

    logic               resp_n, pmem_read_n, pmem_write_n;
    logic [S_LINE-1:0]  rdata_n, pmem_wdata_n;
    logic [31:0]        pmem_address_n;

    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   tag;
    logic [31:0]        line_addr;
    logic               hit;
    logic [WIDTH-1:0]   hit_way;
    logic               inv_found;
    logic [WIDTH-1:0]   inv_way;
    logic [WIDTH-1:0]   plru_way;
    logic [WIDTH-1:0]   victim;
    logic [S_LINE-1:0]  merged;
    logic               fill_en, wr_hit_en, touch_en;

    // Flip every node on the path to `way` so it points at the opposite subtree.
    function automatic logic [NUM_WAYS-1:1] plru_touch(input logic [NUM_WAYS-1:1] bits,
                                                       input logic [WIDTH-1:0]    way);
        logic [NUM_WAYS-1:1] b;
        logic [WIDTH-1:0]    node;
        logic                dir;
        b    = bits;
        node = WIDTH'(1);
        for (int l = WIDTH - 1; l >= 0; l--) begin
            dir     = way[l];
            b[node] = ~dir;
            node    = WIDTH'({node, dir});
        end
        return b;
    endfunction

    // Address decomposition; the line address is the request with its offset bits cleared.
    always_comb begin
        idx       = mem_address[S_OFFSET +: S_INDEX];
        tag       = mem_address[31 -: S_TAG];
        line_addr = mem_address & ~32'(S_MASK - 1);
    end

    // Tag compare, lowest invalid way, PLRU walk, victim selection and write merge.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        plru_way  = WIDTH'(1);
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WIDTH'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WIDTH'(w);
            end
        end
        for (int l = 0; l < WIDTH; l++) begin
            plru_way = WIDTH'({plru_way, plru_q[idx][plru_way]});
        end
        victim = inv_found ? inv_way : plru_way;
        merged = line_q[idx][hit_way];
        for (int b = 0; b < S_MASK; b++) begin
            if (mem_byte_enable256[b]) begin
                merged[8*b +: 8] = mem_wdata256[8*b +: 8];
            end
        end
    end

    // Next-state, array-update strobes and next values of the registered outputs.
    always_comb begin
        state_n        = state_q;
        victim_n       = victim_q;
        resp_n         = 1'b0;
        rdata_n        = mem_rdata256;
        pmem_address_n = pmem_address;
        pmem_wdata_n   = pmem_wdata256;
        fill_en        = 1'b0;
        wr_hit_en      = 1'b0;
        touch_en       = 1'b0;
        case (state_q)
            IDLE: begin
                // The cycle carrying mem_resp still sees the old request; skip it.
                if ((mem_read || mem_write) && !mem_resp) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    resp_n    = 1'b1;
                    touch_en  = 1'b1;
                    wr_hit_en = mem_write;
                    rdata_n   = mem_write ? merged : line_q[idx][hit_way];
                    state_n   = IDLE;
                end else begin
                    victim_n = victim;
                    if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                        state_n        = WRITEBACK;
                        pmem_address_n = {tag_q[idx][victim], idx, {S_OFFSET{1'b0}}};
                        pmem_wdata_n   = line_q[idx][victim];
                    end else begin
                        state_n        = FILL;
                        pmem_address_n = line_addr;
                    end
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_n        = FILL;
                    pmem_address_n = line_addr;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    fill_en = 1'b1;
                    state_n = CHECK;
                end
            end
            default: state_n = IDLE;
        endcase
        pmem_read_n  = (state_n == FILL);
        pmem_write_n = (state_n == WRITEBACK);
    end

    // State and registered outputs; reset drops any outstanding memory request at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            victim_q      <= '0;
            mem_resp      <= 1'b0;
            mem_rdata256  <= '0;
            pmem_read     <= 1'b0;
            pmem_write    <= 1'b0;
            pmem_address  <= '0;
            pmem_wdata256 <= '0;
        end else begin
            state_q       <= state_n;
            victim_q      <= victim_n;
            mem_resp      <= resp_n;
            mem_rdata256  <= rdata_n;
            pmem_read     <= pmem_read_n;
            pmem_write    <= pmem_write_n;
            pmem_address  <= pmem_address_n;
            pmem_wdata256 <= pmem_wdata_n;
        end
    end

    // Valid, dirty and PLRU status bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            plru_q  <= '0;
        end else begin
            if (fill_en) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
            if (wr_hit_en) begin
                dirty_q[idx][hit_way] <= 1'b1;
            end
            if (touch_en) begin
                plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            end
        end
    end

    // Line and tag arrays: fills install the memory line, write hits merge enabled bytes.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_q[idx][victim_q] <= pmem_rdata256;
            tag_q[idx][victim_q]  <= tag;
        end
        if (wr_hit_en) begin
            line_q[idx][hit_way] <= merged;
        end
    end

endmodule

// File: tb/tb_nway_cache.sv
// Bench for nway_cache: directed scenarios plus random traffic against a behavioural model.
module tb_nway_cache;

    localparam int unsigned S_OFFSET = 5;
    localparam int unsigned S_INDEX  = 3;
    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int unsigned S_MASK   = 2**S_OFFSET;
    localparam int unsigned S_LINE   = 8 * S_MASK;
    localparam int unsigned NSETS    = 2**S_INDEX;
    localparam int          TIMEOUT  = 150;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0]       mem_address = '0;
    logic [S_LINE-1:0] mem_wdata256 = '0;
    logic [S_MASK-1:0] mem_byte_enable256 = '0;
    logic [S_LINE-1:0] mem_rdata256;
    logic              mem_resp;
    logic              pmem_read, pmem_write;
    logic [31:0]       pmem_address;
    logic [S_LINE-1:0] pmem_wdata256;
    logic [S_LINE-1:0] pmem_rdata256 = '0;
    logic              pmem_resp = 1'b0;

    nway_cache #(.S_OFFSET(S_OFFSET), .S_INDEX(S_INDEX), .NUM_WAYS(NUM_WAYS)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata256(pmem_wdata256), .pmem_rdata256(pmem_rdata256), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [S_LINE-1:0] obs, input logic [S_LINE-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [S_LINE-1:0] rand_line();
        logic [S_LINE-1:0] l;
        for (int i = 0; i < S_LINE / 32; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] mk_addr(input int t, input int s, input int off);
        return (32'(t) << (S_OFFSET + S_INDEX)) | (32'(s) << S_OFFSET) | 32'(off);
    endfunction

    // Backing memory, created lazily with random contents.
    logic [S_LINE-1:0] pmem [logic [31:0]];
    function automatic logic [S_LINE-1:0] mem_get(input logic [31:0] a);
        if (!pmem.exists(a)) pmem[a] = rand_line();
        return pmem[a];
    endfunction

    typedef struct {
        bit                wr;
        logic [31:0]       addr;
        logic [S_LINE-1:0] data;
    } xfer_t;

    xfer_t log_q[$];
    int    fill_cyc = 0;
    bit    hold_mem = 1'b0;
    bit    noise    = 1'b0;

    // Memory responder: random latency, checks request stability, logs completed transfers.
    initial begin : responder
        bit                busy = 1'b0;
        bit                wr0 = 1'b0;
        int                wait_n = 0;
        logic [31:0]       a0 = '0;
        logic [S_LINE-1:0] d0 = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            chk("pmem_rd_wr_exclusive", S_LINE'(pmem_read & pmem_write), '0);
            if (!rst || !(pmem_read || pmem_write)) begin
                busy = 1'b0;
                if (noise) begin
                    pmem_resp     = 1'($urandom_range(0, 1));
                    pmem_rdata256 = rand_line();
                end
            end else if (!busy) begin
                busy   = 1'b1;
                wr0    = pmem_write;
                a0     = pmem_address;
                d0     = pmem_wdata256;
                wait_n = $urandom_range(0, 3);
                chk("pmem_addr_aligned", S_LINE'(pmem_address & 32'(S_MASK - 1)), '0);
            end else begin
                chk("pmem_kind_held", S_LINE'(pmem_write), S_LINE'(wr0));
                chk("pmem_addr_held", S_LINE'(pmem_address), S_LINE'(a0));
                if (wr0) chk("pmem_wdata_held", pmem_wdata256, d0);
            end
            if (busy && !hold_mem) begin
                if (wait_n == 0) begin
                    if (wr0) begin
                        pmem[a0] = d0;
                    end else begin
                        pmem_rdata256 = mem_get(a0);
                        fill_cyc      = cyc;
                    end
                    log_q.push_back(xfer_t'{wr0, a0, wr0 ? d0 : pmem_rdata256});
                    pmem_resp = 1'b1;
                    busy      = 1'b0;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    // Reference model: per-set ways plus a tree-PLRU described by halving the way range.
    logic [S_LINE-1:0] m_data  [NSETS][NUM_WAYS];
    logic [S_TAG-1:0]  m_tag   [NSETS][NUM_WAYS];
    bit                m_valid [NSETS][NUM_WAYS];
    bit                m_dirty [NSETS][NUM_WAYS];
    bit                m_upper [NSETS][NUM_WAYS];  // per node: 1 = victim lies in upper half

    task automatic model_reset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_upper[s][w] = 1'b0;
            end
    endtask

    function automatic int plru_victim(input int s);
        int lo = 0, size = NUM_WAYS, node = 1;
        while (size > 1) begin
            size = size / 2;
            if (m_upper[s][node]) begin lo += size; node = 2 * node + 1; end
            else node = 2 * node;
        end
        return lo;
    endfunction

    task automatic plru_use(input int s, input int w);
        int lo = 0, size = NUM_WAYS, node = 1;
        bit up;
        while (size > 1) begin
            size = size / 2;
            up = (w >= lo + size);
            m_upper[s][node] = !up;
            if (up) lo += size;
            node = 2 * node + int'(up);
        end
    endtask

    // One CPU transaction: predict with the model, drive, then check response and memory traffic.
    task automatic do_op(input bit wr, input logic [31:0] addr,
                         input logic [S_LINE-1:0] wd, input logic [S_MASK-1:0] be);
        int s, w, c0, k;
        logic [S_TAG-1:0]  t;
        logic [31:0]       la;
        bit                was_hit;
        logic [S_LINE-1:0] exp_rd;
        xfer_t             exp_q[$];
        s  = int'(addr[S_OFFSET +: S_INDEX]);
        t  = addr[31 -: S_TAG];
        la = addr & ~32'(S_MASK - 1);
        w  = -1;
        for (int i = 0; i < NUM_WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
        was_hit = (w >= 0);
        if (!was_hit) begin
            for (int i = NUM_WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
            if (w < 0) w = plru_victim(s);
            if (m_valid[s][w] && m_dirty[s][w])
                exp_q.push_back(xfer_t'{1'b1, mk_addr(int'(m_tag[s][w]), s, 0), m_data[s][w]});
            exp_q.push_back(xfer_t'{1'b0, la, mem_get(la)});
            m_data[s][w]  = mem_get(la);
            m_tag[s][w]   = t;
            m_valid[s][w] = 1'b1;
            m_dirty[s][w] = 1'b0;
        end
        plru_use(s, w);
        if (wr) begin
            for (int b = 0; b < S_MASK; b++) if (be[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
            m_dirty[s][w] = 1'b1;
        end
        exp_rd = m_data[s][w];

        mem_read           = !wr;
        mem_write          = wr;
        mem_address        = addr;
        mem_wdata256       = wd;
        mem_byte_enable256 = be;
        c0 = cyc;
        log_q.delete();
        k = 0;
        do begin @(negedge clk); k++; end while (mem_resp !== 1'b1 && k < TIMEOUT);
        chk("mem_resp_seen", S_LINE'(mem_resp), 1);
        if (was_hit) chk("hit_latency", S_LINE'(cyc - c0), 2);
        else         chk("miss_latency", S_LINE'(cyc - fill_cyc), 2);
        if (!wr) chk("read_data", mem_rdata256, exp_rd);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk("xfer_count", S_LINE'(log_q.size()), S_LINE'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("xfer_kind", S_LINE'(log_q[i].wr), S_LINE'(exp_q[i].wr));
            chk("xfer_addr", S_LINE'(log_q[i].addr), S_LINE'(exp_q[i].addr));
            if (exp_q[i].wr) chk("xfer_wb_data", log_q[i].data, exp_q[i].data);
        end
        @(negedge clk);
        chk("resp_one_cycle", S_LINE'(mem_resp), 0);
        chk("pmem_idle_after", S_LINE'(pmem_read | pmem_write), 0);
    endtask

    initial begin : stim
        logic [S_LINE-1:0] wd;
        logic [31:0]       x;
        int                k;
        model_reset();

        // Reset values
        @(negedge clk);
        chk("rst_mem_resp", S_LINE'(mem_resp), 0);
        chk("rst_pmem_read", S_LINE'(pmem_read), 0);
        chk("rst_pmem_write", S_LINE'(pmem_write), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Cold read then repeat hit
        do_op(1'b0, 32'h40, '0, '0);
        do_op(1'b0, 32'h40, '0, '0);
        chk("repeat_read_no_traffic", S_LINE'(log_q.size()), 0);

        // Single-byte write
        wd = rand_line();
        wd[31:24] = 8'hAA;
        do_op(1'b1, 32'h40, wd, 32'h0000_0008);
        do_op(1'b0, 32'h40, '0, '0);
        chk("byte3_written", S_LINE'(mem_rdata256[31:24]), S_LINE'(8'hAA));

        // Tree-PLRU: fill ways 0..3, touch way 0, next miss must take way 2
        for (int t = 1; t <= 4; t++) do_op(1'b0, mk_addr(t, 0, 0), '0, '0);
        do_op(1'b1, mk_addr(1, 0, 4), rand_line(), S_MASK'($urandom));
        do_op(1'b0, mk_addr(5, 0, 0), '0, '0);
        do_op(1'b0, mk_addr(1, 0, 0), '0, '0);
        chk("way0_kept", S_LINE'(log_q.size()), 0);
        do_op(1'b0, mk_addr(3, 0, 0), '0, '0);
        chk("way2_was_evicted", S_LINE'(log_q.size() != 0), 1);

        // Five dirty lines into one set: the fifth writes back before filling
        for (int t = 1; t <= 5; t++) do_op(1'b1, mk_addr(t, 1, 0), rand_line(), '1);
        chk("dirty_evict_xfers", S_LINE'(log_q.size()), 2);
        if (log_q.size() > 0) chk("writeback_first", S_LINE'(log_q[0].wr), 1);

        // Reset in the middle of a fill
        x = mk_addr(9, 5, 12);
        hold_mem    = 1'b1;
        mem_read    = 1'b1;
        mem_address = x;
        k = 0;
        while (pmem_read !== 1'b1 && k < TIMEOUT) begin @(negedge clk); k++; end
        chk("fill_request_up", S_LINE'(pmem_read), 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_drops_pmem_read", S_LINE'(pmem_read), 0);
        chk("rst_no_resp", S_LINE'(mem_resp), 0);
        mem_read = 1'b0;
        model_reset();
        @(negedge clk);
        rst      = 1'b1;
        hold_mem = 1'b0;
        @(negedge clk);
        do_op(1'b0, x, '0, '0);
        chk("post_rst_miss", S_LINE'(log_q.size()), 1);
        do_op(1'b0, 32'h40, '0, '0);

        // Random traffic over a few tags in two sets
        for (int n = 0; n < 250; n++) begin
            do_op(1'($urandom_range(0, 1)),
                  mk_addr($urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, S_MASK - 1)),
                  rand_line(), S_MASK'($urandom));
        end

        // Idle with stray pmem_resp pulses: no response, no memory request
        noise = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("idle_no_resp", S_LINE'(mem_resp), 0);
            chk("idle_no_pmem", S_LINE'(pmem_read | pmem_write), 0);
        end
        noise = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
